// File: rtl/spec_acc_pkg.sv
// Shared types and default widths for the spectrum-accumulation sequencer.
// SPEC_ACC_GAP_EN adds the GAP state used for idle cycles between frames.
package spec_acc_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int LEN_W_DEF = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_ACCUM = 3'd2,
`ifdef SPEC_ACC_GAP_EN
    ST_GAP   = 3'd3,
`endif
    ST_HOLD  = 3'd4
  } state_e;

endpackage

// File: rtl/spec_acc_sequencer_if.sv
// Control/status bundle between the host register block (master) and the sequencer (slave).
// SPEC_ACC_GAP_EN adds the gap_len configuration field.
interface spec_acc_sequencer_if import spec_acc_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = LEN_W_DEF
);
  // start/abort are level requests sampled each clock; there is no ready. A start
  // is taken only in IDLE/HOLD with abort low, and its outcome shows one cycle
  // later as busy (accepted) or err_cfg (rejected config).
  logic             start;
  logic             abort;
  logic [LEN_W-1:0] frame_len;
  logic [CNT_W-1:0] num_frames;
`ifdef SPEC_ACC_GAP_EN
  logic [LEN_W-1:0] gap_len;
`endif
  logic             capture_en;
  logic             spec_acc_done;
  logic [CNT_W-1:0] frames_done;
  logic             busy;
  logic             done;
  logic             err_cfg;
  state_e           dbg_state;

  modport master (
`ifdef SPEC_ACC_GAP_EN
    output gap_len,
`endif
    output start, abort, frame_len, num_frames,
    input  capture_en, spec_acc_done, frames_done, busy, done, err_cfg, dbg_state
  );

  modport slave (
`ifdef SPEC_ACC_GAP_EN
    input  gap_len,
`endif
    input  start, abort, frame_len, num_frames,
    output capture_en, spec_acc_done, frames_done, busy, done, err_cfg, dbg_state
  );

endinterface

// File: rtl/spec_acc_frame_timer.sv
// Loadable down-counter shared by the ACCUM and GAP phases. tc is high while the
// count is zero; tc_next is the value tc takes after the coming edge.
module spec_acc_frame_timer #(
  parameter int LEN_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [LEN_W-1:0] load_val,
  output logic             tc,
  output logic             tc_next
);

  logic [LEN_W-1:0] count_q, count_d;
  logic             tc_q, tc_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - LEN_W'(1);
    end
    tc_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b1;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign tc      = tc_q;
  assign tc_next = tc_d;

endmodule

// File: rtl/spec_acc_sequencer.sv
// Spectrum-accumulation sequencer: ARM clears the pulse counter, then num_frames
// frames of frame_len cycles run with a done pulse per frame. Optional SPEC_ACC_GAP_EN.
module spec_acc_sequencer import spec_acc_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  spec_acc_sequencer_if.slave  bus
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] frames_done_q, frames_done_d;
  logic             capture_en_q, capture_en_d;
  logic             spec_acc_done_q, spec_acc_done_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_cfg_q, err_cfg_d;
`ifdef SPEC_ACC_GAP_EN
  logic [LEN_W-1:0] gap_q, gap_d;
`endif

  logic             tmr_load, tmr_en, tmr_tc, tmr_tc_next;
  logic [LEN_W-1:0] tmr_val;
  logic             cfg_ok;

  spec_acc_frame_timer #(.LEN_W(LEN_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .tc       (tmr_tc),
    .tc_next  (tmr_tc_next)
  );

  assign cfg_ok = (bus.frame_len != '0) && (bus.num_frames != '0);

  // Next-state and configuration logic; the timer is loaded with length-1 so its
  // terminal count lands on the last cycle of the phase.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    num_d         = num_q;
    frames_done_d = frames_done_q;
    done_d        = 1'b0;
    err_cfg_d     = 1'b0;
    tmr_load      = 1'b0;
    tmr_en        = 1'b0;
    tmr_val       = len_q - LEN_W'(1);
`ifdef SPEC_ACC_GAP_EN
    gap_d         = gap_q;
`endif
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.start) begin
          if (cfg_ok) begin
            state_d       = ST_ARM;
            len_d         = bus.frame_len;
            num_d         = bus.num_frames;
            frames_done_d = '0;
`ifdef SPEC_ACC_GAP_EN
            gap_d         = bus.gap_len;
`endif
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end
      ST_ARM: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_ACCUM;
          tmr_load = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (tmr_tc) begin
          frames_done_d = frames_done_q + CNT_W'(1);
          if ((frames_done_q + CNT_W'(1)) == num_q) begin
            state_d = ST_HOLD;
            done_d  = 1'b1;
          end else begin
`ifdef SPEC_ACC_GAP_EN
            if (gap_q != '0) begin
              state_d = ST_GAP;
              tmr_val = gap_q - LEN_W'(1);
            end
`endif
            tmr_load = 1'b1;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
`ifdef SPEC_ACC_GAP_EN
      ST_GAP: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (tmr_tc) begin
          state_d  = ST_ACCUM;
          tmr_load = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are registered
  // alongside it and line up with the state they describe.
  always_comb begin
    capture_en_d    = (state_d != ST_IDLE) && (state_d != ST_ARM);
    busy_d          = (state_d != ST_IDLE) && (state_d != ST_HOLD);
    spec_acc_done_d = (state_d == ST_ACCUM) && tmr_tc_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      len_q           <= '0;
      num_q           <= '0;
      frames_done_q   <= '0;
      capture_en_q    <= 1'b0;
      spec_acc_done_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_cfg_q       <= 1'b0;
`ifdef SPEC_ACC_GAP_EN
      gap_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      num_q           <= num_d;
      frames_done_q   <= frames_done_d;
      capture_en_q    <= capture_en_d;
      spec_acc_done_q <= spec_acc_done_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_cfg_q       <= err_cfg_d;
`ifdef SPEC_ACC_GAP_EN
      gap_q           <= gap_d;
`endif
    end
  end

  assign bus.capture_en    = capture_en_q;
  assign bus.spec_acc_done = spec_acc_done_q;
  assign bus.frames_done   = frames_done_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err_cfg       = err_cfg_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: doc/spec_acc_sequencer.md
# spec_acc_sequencer

Generates the spectrum-accumulation timing seen by the pulse-counting logic. On a start command it clears downstream counters, asserts `capture_en`, and runs `num_frames` accumulation frames of `frame_len` cycles each. It emits one single-cycle `spec_acc_done` pulse at the end of every frame, then holds `capture_en` high so the downstream count stays readable. It sits between the host/control register block and the pulse counter, and is the transmitter side of the `capture_en`/`spec_acc_done` interface.

## Interface
- CNT_W, 16, width of frame count; matches 16-bit downstream pulse count
- LEN_W, 24, width of frame length and gap length
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  run request; sampled in IDLE or HOLD only
- abort  in  1  terminate run; wins over start
- frame_len  in  LEN_W  cycles per frame; latched on accepted start
- num_frames  in  CNT_W  frames per run; latched on accepted start
- gap_len  in  LEN_W  idle cycles between frames; present only with SPEC_ACC_GAP_EN
- capture_en  out  1  accumulation window; low clears downstream counter
- spec_acc_done  out  1  one-cycle end-of-frame pulse
- frames_done  out  CNT_W  frames completed in current/last run
- busy  out  1  high in ARM/ACCUM/GAP
- done  out  1  one-cycle pulse on run completion
- err_cfg  out  1  one-cycle pulse on start rejected (frame_len==0 or num_frames==0)

## Operation
- States: IDLE, ARM, ACCUM, GAP (macro only), HOLD. Reset → IDLE; all outputs 0.
- IDLE: capture_en=0. HOLD: capture_en=1, busy=0.
- Start accepted in IDLE/HOLD with nonzero config → ARM; frames_done←0; config latched. In ARM, capture_en=0 for exactly one cycle (clears counter).
- Zero config: err_cfg=1 next cycle, state unchanged, nothing latched.
- ARM → ACCUM. ACCUM lasts frame_len cycles; spec_acc_done=1 in the last cycle; frames_done increments at the edge ending that cycle.
- After a frame: if frames_done+1==num_frames → HOLD with done=1 for the first HOLD cycle; else → GAP (gap_len>0, macro on) or ACCUM.
- GAP: capture_en=1, no pulse, lasts gap_len cycles.
- Abort in ARM/ACCUM/GAP/HOLD → IDLE next edge: capture_en=0, no pulse, no done; frames_done retained. Abort in IDLE is ignored.
- Start while busy is ignored. Input changes after latch have no effect on the current run.
- Counters are full-width; frame_len=1 gives a pulse every ACCUM cycle. No wrap: frames_done ≤ num_frames ≤ 2^CNT_W−1.

## Timing
- start high at edge T0 (accepted): ARM cycle starts at T0+1; ACCUM starts at T0+2; capture_en rises at T0+2.
- Pulse k is high in the cycle starting at edge T0+1+k·L+(k−1)·G (L=frame_len, G=gap_len, G=0 without macro).
- done is high in the cycle starting at T0+2+N·L+(N−1)·G; busy falls at that same edge.
- err_cfg is high in the cycle starting at T0+1.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- SPEC_ACC_GAP_EN defined: gap_len port and GAP state exist; G cycles are inserted between frames, with capture_en held high.
- Not defined: no gap_len port, no GAP state; frames run back-to-back (G=0).

## Structure
- Shared package spec_acc_pkg: state enum typedef, default CNT_W/LEN_W constants.
- One sub-module, spec_acc_frame_timer: loadable down-counter (LEN_W) with load, enable and terminal-count pulse. Instantiated once and reused for both ACCUM and GAP timing.

## Test plan
- L=4, N=3, start at T0 → pulses at T0+5, T0+9, T0+13; done at T0+14; frames_done=3; capture_en 0 at T0+1, 1 from T0+2 onward.
- L=1, N=2 → pulses at T0+2 and T0+3; done at T0+4.
- Macro on, L=3, N=2, G=2 → pulses at T0+4 and T0+9; capture_en stays high through the gap.
- L=10, N=5, abort at T0+15 → IDLE at T0+16, capture_en=0, frames_done=1, no done.
- frame_len=0 or num_frames=0 start → err_cfg at T0+1, busy stays 0; start+abort same cycle in IDLE → no run; rst mid-ACCUM → all outputs 0 immediately.
- Start in HOLD after a completed run → capture_en low for exactly one cycle, frames_done←0, new run timed as above.
